mode_register: RTL and testbench

//  Parametrised multi-mode data register for the CPU datapath (accumulator / B / PC-style use).
//  - Generalises the plain load/clear register: adds width parameter, INC/DEC/shift/rotate modes,

---
 rtl/mode_register.sv | 80 ++++++++
 tb/tb_mode_register.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/mode_register.sv
// Multi-mode datapath register: load, clear, increment/decrement, shift and rotate,
// with carry and zero flags and a saturating counter of accepted loads.
module mode_register #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned COUNT_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   en,
  input  logic [2:0]             op,
  input  logic [WIDTH-1:0]       in,
  input  logic                   ser_in,
  output logic [WIDTH-1:0]       out,
  output logic                   carry,
  output logic                   zero,
  output logic [COUNT_WIDTH-1:0] count
);

  typedef enum logic [2:0] {
    OP_HOLD = 3'b000,
    OP_LOAD = 3'b001,
    OP_INC  = 3'b010,
    OP_DEC  = 3'b011,
    OP_SHL  = 3'b100,
    OP_SHR  = 3'b101,
    OP_ROL  = 3'b110,
    OP_CLRD = 3'b111
  } op_t;

  op_t          cur_op;
  logic [WIDTH:0] inc_val;
  logic [WIDTH:0] dec_val;

  // The extra top bit of the widened sum/difference is the carry/borrow.
  always_comb begin
    cur_op  = op_t'(op);
    inc_val = {1'b0, out} + (WIDTH+1)'(1);
    dec_val = {1'b0, out} - (WIDTH+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      out   <= '0;
      carry <= 1'b0;
      count <= '0;
    end else if (en) begin
      unique case (cur_op)
        OP_HOLD: ;
        OP_LOAD: begin
          out   <= in;
          carry <= 1'b0;
          if (count != '1)
            count <= count + COUNT_WIDTH'(1);
        end
        OP_INC: {carry, out} <= inc_val;
        OP_DEC: {carry, out} <= dec_val;
        OP_SHL: begin
          out   <= {out[WIDTH-2:0], ser_in};
          carry <= out[WIDTH-1];
        end
        OP_SHR: begin
          out   <= {ser_in, out[WIDTH-1:1]};
          carry <= out[0];
        end
        OP_ROL: begin
          out   <= {out[WIDTH-2:0], out[WIDTH-1]};
          carry <= out[WIDTH-1];
        end
        OP_CLRD: begin
          out   <= '0;
          carry <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign zero = (out == '0);

endmodule

// File: tb/tb_mode_register.sv
// Self-checking bench for mode_register: directed scenarios plus randomized
// stimulus compared against an arithmetic reference model.
module tb_mode_register;

  localparam int W    = 4;
  localparam int CW   = 4;
  localparam int MODO = 1 << W;
  localparam int MAXC = (1 << CW) - 1;

  localparam logic [2:0] HOLD = 3'd0, LOAD = 3'd1, INC = 3'd2, DEC = 3'd3,
                         SHL  = 3'd4, SHR  = 3'd5, ROL = 3'd6, CLRD = 3'd7;

  logic          clk = 1'b0;
  logic          clr, en, ser_in;
  logic [2:0]    op;
  logic [W-1:0]  din;
  logic [W-1:0]  out_w;
  logic          carry_w, zero_w;
  logic [CW-1:0] count_w;

  int errors = 0;
  int checks = 0;

  int m_out   = 0;
  int m_carry = 0;
  int m_count = 0;

  mode_register #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
    .clk    (clk),
    .clr    (clr),
    .en     (en),
    .op     (op),
    .in     (din),
    .ser_in (ser_in),
    .out    (out_w),
    .carry  (carry_w),
    .zero   (zero_w),
    .count  (count_w)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference behaviour expressed as plain modular arithmetic.
  task automatic model(input logic c, input logic e, input logic [2:0] o,
                       input int d, input int s);
    int old;
    old = m_out;
    if (c) begin
      m_out = 0; m_carry = 0; m_count = 0;
    end else if (e) begin
      case (o)
        LOAD: begin
          m_out = d; m_carry = 0;
          if (m_count < MAXC) m_count++;
        end
        INC: begin m_carry = (old + 1) / MODO; m_out = (old + 1) % MODO; end
        DEC: begin m_carry = (old == 0); m_out = (old + MODO - 1) % MODO; end
        SHL: begin m_carry = old / (MODO/2); m_out = (old * 2) % MODO + s; end
        SHR: begin m_carry = old % 2; m_out = s * (MODO/2) + old / 2; end
        ROL: begin m_carry = old / (MODO/2); m_out = (old * 2) % MODO + old / (MODO/2); end
        CLRD: begin m_out = 0; m_carry = 0; end
        default: ;
      endcase
    end
  endtask

  task automatic step(input string tag, input logic c, input logic e,
                      input logic [2:0] o, input logic [W-1:0] d, input logic s);
    clr = c; en = e; op = o; din = d; ser_in = s;
    @(posedge clk);
    #1;
    model(c, e, o, int'(d), int'(s));
    check({tag, ".out"},   int'(out_w),   m_out);
    check({tag, ".carry"}, int'(carry_w), m_carry);
    check({tag, ".zero"},  int'(zero_w),  int'(m_out == 0));
    check({tag, ".count"}, int'(count_w), m_count);
  endtask

  initial begin
    clr = 1'b1; en = 1'b1; op = LOAD; din = 4'b1010; ser_in = 1'b0;

    // Reset beats a concurrent LOAD
    step("rst", 1, 1, LOAD, 4'b1010, 0);
    check("rst_out_const", int'(out_w), 0);
    check("rst_zero_const", int'(zero_w), 1);
    check("rst_count_const", int'(count_w), 0);

    // Load then hold with en=0
    step("ld", 0, 1, LOAD, 4'b0011, 0);
    for (int i = 0; i < 3; i++) step("hold_en0", 0, 0, LOAD, 4'b1111, 1);
    check("hold_out_const", int'(out_w), 3);
    check("hold_count_const", int'(count_w), 1);

    // INC wrap
    step("inc_ld", 0, 1, LOAD, 4'b1110, 0);
    step("inc1", 0, 1, INC, 4'b0000, 0);
    check("inc1_const", int'({carry_w, out_w}), 15);
    step("inc2", 0, 1, INC, 4'b0000, 0);
    check("inc2_const", int'({carry_w, zero_w, out_w}), 6'b110000);

    // DEC borrow
    step("dec_ld", 0, 1, LOAD, 4'b0001, 0);
    step("dec1", 0, 1, DEC, 4'b0000, 0);
    check("dec1_const", int'({carry_w, zero_w, out_w}), 6'b010000);
    step("dec2", 0, 1, DEC, 4'b0000, 0);
    check("dec2_const", int'({carry_w, out_w}), 5'b11111);

    // Carry persists across HOLD
    step("hold_carry", 0, 1, HOLD, 4'b0101, 1);
    check("hold_carry_const", int'(carry_w), 1);

    // Shifts and rotate
    step("sh_ld", 0, 1, LOAD, 4'b1001, 0);
    step("shl", 0, 1, SHL, 4'b0000, 0);
    check("shl_const", int'({carry_w, out_w}), 5'b10010);
    step("shr", 0, 1, SHR, 4'b0000, 1);
    check("shr_const", int'({carry_w, out_w}), 5'b01001);
    step("rol", 0, 1, ROL, 4'b0000, 0);
    check("rol_const", int'({carry_w, out_w}), 5'b10011);

    // Count saturation
    step("sat_rst", 1, 0, HOLD, 4'b0000, 0);
    for (int i = 1; i <= 17; i++) begin
      step("sat_ld", 0, 1, LOAD, W'(i), 0);
      if (i == 15) check("sat15_const", int'(count_w), MAXC);
    end
    check("sat17_const", int'(count_w), MAXC);
    step("clrd", 0, 1, CLRD, 4'b1111, 1);
    check("clrd_count_const", int'(count_w), MAXC);
    check("clrd_out_const", int'(out_w), 0);

    // Randomized stimulus against the model
    for (int i = 0; i < 600; i++) begin
      step("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) != 0),
           3'($urandom_range(0, 7)), W'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
